// File: rtl/pu_msp430_gpio_pkg.sv
// Shared definitions for the MSP430-style GPIO pin controller.
//   EDGE_RISE / EDGE_FALL : meaning of the per-pin edge-select bit
//   *_DEF                 : default parameter values for the bank
//   deb_cnt_w()           : width of a per-pin debounce counter
//   deb_max()             : number of stable cycles a change must survive
package pu_msp430_gpio_pkg;

    localparam logic EDGE_RISE = 1'b0;
    localparam logic EDGE_FALL = 1'b1;

    localparam int WIDTH_DEF       = 8;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int DEB_CYC_DEF     = 0;

    // DEB_CYC = 0 behaves like a one-cycle filter, so the counter never
    // shrinks below one bit.
    function automatic int deb_cnt_w(input int deb_cyc);
        int w;
        w = $clog2(deb_cyc + 1);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int deb_max(input int deb_cyc);
        return (deb_cyc < 1) ? 1 : deb_cyc;
    endfunction

endpackage

// File: rtl/pu_msp430_gpio_sync_deb.sv
// One pin of the input path: synchronizer, debounce filter, in_val flop
// and a registered edge pulse.
//   clk, rst_n  : clock, asynchronous active-low reset
//   armed       : 0 during the startup window; in_val then tracks s freely
//   pad         : asynchronous pad input
//   ies         : edge select (EDGE_RISE / EDGE_FALL)
//   in_val      : synchronized, debounced pin level
//   edge_pulse  : high for one cycle right after in_val changed in the
//                 selected direction while armed
module pu_msp430_gpio_sync_deb
    import pu_msp430_gpio_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DEB_CYC     = DEB_CYC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic armed,
    input  logic pad,
    input  logic ies,
    output logic in_val,
    output logic edge_pulse
);

    localparam int               CNT_W    = deb_cnt_w(DEB_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(deb_max(DEB_CYC) - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic [CNT_W-1:0]       cnt;

    assign s = sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pad};
        end
    end

    // The edge pulse is produced at the moment in_val is loaded, using the
    // value being loaded; a change of ies alone therefore never pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            in_val     <= 1'b0;
            edge_pulse <= 1'b0;
        end else if (!armed) begin
            in_val     <= s;
            cnt        <= '0;
            edge_pulse <= 1'b0;
        end else if (s == in_val) begin
            cnt        <= '0;
            edge_pulse <= 1'b0;
        end else if (cnt == CNT_LAST) begin
            in_val     <= s;
            cnt        <= '0;
            edge_pulse <= (s && (ies == EDGE_RISE)) || (!s && (ies == EDGE_FALL));
        end else begin
            cnt        <= cnt + CNT_W'(1);
            edge_pulse <= 1'b0;
        end
    end

endmodule

// File: rtl/pu_msp430_gpio_pin_ctrl.sv
// Core-side controller for a bank of WIDTH bidirectional pad cells.
//   mclk, puc_rst_n        : clock, asynchronous active-low reset
//   dir_i, od_i            : direction and open-drain select per pin
//   out_wr, out_wdata      : output register write
//   ies_i, ie_i            : edge select and interrupt enable per pin
//   ifg_set, ifg_clr       : software set / clear of interrupt flags
//   pad_din                : asynchronous pad inputs
//   pad_dout_en, pad_dout  : pad drive controls
//   out_reg, in_val, ifg   : register readbacks
//   irq                    : any enabled flag pending
module pu_msp430_gpio_pin_ctrl
    import pu_msp430_gpio_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DEB_CYC     = DEB_CYC_DEF
) (
    input  logic             mclk,
    input  logic             puc_rst_n,
    input  logic [WIDTH-1:0] dir_i,
    input  logic [WIDTH-1:0] od_i,
    input  logic             out_wr,
    input  logic [WIDTH-1:0] out_wdata,
    input  logic [WIDTH-1:0] ies_i,
    input  logic [WIDTH-1:0] ie_i,
    input  logic [WIDTH-1:0] ifg_set,
    input  logic [WIDTH-1:0] ifg_clr,
    input  logic [WIDTH-1:0] pad_din,
    output logic [WIDTH-1:0] pad_dout_en,
    output logic [WIDTH-1:0] pad_dout,
    output logic [WIDTH-1:0] out_reg,
    output logic [WIDTH-1:0] in_val,
    output logic [WIDTH-1:0] ifg,
    output logic             irq
);

    // The startup window covers the synchronizer fill plus one more cycle,
    // so that in_val has already caught up with the settled s by the time
    // edges are allowed; a pad held high through reset thus flags nothing.
    localparam int                 START_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [START_W-1:0] START_DONE = START_W'(SYNC_STAGES + 1);

    logic [START_W-1:0] start_cnt;
    logic               armed;
    logic [WIDTH-1:0]   edge_pulse;

    assign armed = (start_cnt == START_DONE);

    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            start_cnt <= '0;
        end else if (!armed) begin
            start_cnt <= start_cnt + START_W'(1);
        end
    end

    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            out_reg <= '0;
        end else if (out_wr) begin
            out_reg <= out_wdata;
        end
    end

    // Set (hardware edge or software) wins over clear.
    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            ifg <= '0;
        end else begin
            ifg <= (ifg & ~ifg_clr) | edge_pulse | ifg_set;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        pu_msp430_gpio_sync_deb #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEB_CYC     (DEB_CYC)
        ) u_sync_deb (
            .clk        (mclk),
            .rst_n      (puc_rst_n),
            .armed      (armed),
            .pad        (pad_din[i]),
            .ies        (ies_i[i]),
            .in_val     (in_val[i]),
            .edge_pulse (edge_pulse[i])
        );
    end

    // Open-drain pins only ever pull low; od takes precedence over dir.
    assign pad_dout    = out_reg & ~od_i;
    assign pad_dout_en = (od_i & ~out_reg) | (~od_i & dir_i);
    assign irq         = |(ifg & ie_i);

endmodule
